// File: rtl/frame_rx_if.sv
// frame_rx_if: serial line and received-frame signals of the frame receiver.
//   en, data_in          line side: bit-sample strobe and serial data
//   data_out, data_vld   received payload and its one-cycle update strobe
//   parity_err           parity result, meaningful while data_vld is high
//   locked, frame_cnt    lock indicator and saturating good-frame count
// master: the side that drives the line and observes the results.
// slave:  the receiver.
interface frame_rx_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic              data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_vld;
  logic              parity_err;
  logic              locked;
  logic [15:0]       frame_cnt;

  modport master (
    output en, data_in,
    input  data_out, data_vld, parity_err, locked, frame_cnt
  );

  modport slave (
    input  en, data_in,
    output data_out, data_vld, parity_err, locked, frame_cnt
  );
endinterface

// File: rtl/frame_rx.sv
// frame_rx: serial frame receiver on the bit-clock domain.
// Hunts the line for a sync pattern, then shifts in one DATA_W-bit payload
// (MSB first) and a parity bit. The payload is presented with a one-cycle
// valid strobe and a parity-error flag; a lock indicator and a saturating
// good-frame count are kept for the self-test logic.
// Ports:
//   clk   bit clock, all logic on the rising edge
//   rst   asynchronous, active-high reset
//   bus   frame_rx_if.slave (en, data_in in; data_out, data_vld,
//         parity_err, locked, frame_cnt out)
//
// state | meaning
// HUNT  | sliding-window search for SYNC_PAT on en strobes
// DATA  | shifting in payload bits, bit_cnt counts 0..DATA_W-1
// PAR   | sampling the parity bit, publishing the frame
module frame_rx #(
  parameter int              DATA_W   = 32,
  parameter int              SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
  parameter bit              PAR_ODD  = 1'b0
) (
  input logic        clk,
  input logic        rst,
  frame_rx_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // Only the newest SYNC_W-1 bits are needed; the incoming bit completes
  // the window.
  logic [SYNC_W-2:0]   sync_q, sync_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_vld_q, data_vld_d;
  logic                parity_err_q, parity_err_d;
  logic                locked_q, locked_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic [SYNC_W-1:0]   sync_win;
  logic                par_err;

  assign sync_win = {sync_q, bus.data_in};
  assign par_err  = (^{shift_q, bus.data_in}) ^ PAR_ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      locked_q     <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_vld_q   <= data_vld_d;
      parity_err_q <= parity_err_d;
      locked_q     <= locked_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_vld_d   = 1'b0;   // strobe never stretches, even across en=0
    parity_err_d = parity_err_q;
    locked_d     = locked_q;
    frame_cnt_d  = frame_cnt_q;

    if (bus.en) begin
      case (state_q)
        HUNT: begin
          sync_d = sync_win[SYNC_W-2:0];
          if (sync_win == SYNC_PAT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {shift_q[DATA_W-2:0], bus.data_in};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PAR;
          end
        end
        PAR: begin
          data_out_d   = shift_q;
          parity_err_d = par_err;
          data_vld_d   = 1'b1;
          if (par_err) begin
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
            if (frame_cnt_q != 16'hFFFF) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
          // Every frame needs a complete fresh sync pattern.
          sync_d    = '0;
          bit_cnt_d = '0;
          state_d   = HUNT;
        end
        default: begin
          state_d = HUNT;
          sync_d  = '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_vld   = data_vld_q;
  assign bus.parity_err = parity_err_q;
  assign bus.locked     = locked_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: scoreboard bench for frame_rx. Expected frame results are
// queued as the parity bit is driven and compared on each data_vld pulse.
module tb_frame_rx;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  frame_rx_if #(.DATA_W(DATA_W)) bus ();

  frame_rx #(
    .DATA_W   (DATA_W),
    .SYNC_W   (8),
    .SYNC_PAT (8'hA5),
    .PAR_ODD  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        locked;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_locked = 1'b0;
  logic [15:0] m_cnt    = 16'h0;
  logic        vld_prev = 1'b0;
  int          strobe_cnt = 0;
  int          last_vld_strobe = 0;
  int          vld_gap = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: counts en strobes and scores every data_vld pulse.
  always @(posedge clk) begin
    if (!rst && bus.en) strobe_cnt++;
    #1;
    if (bus.data_vld) begin
      check_val("vld_stretch", {31'b0, vld_prev}, 32'd0);
      check_val("unexpected_vld", {31'b0, sb_q.size() == 0}, 32'd0);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_val("data_out",   bus.data_out, mon_e.data);
        check_val("parity_err", {31'b0, bus.parity_err}, {31'b0, mon_e.perr});
        check_val("locked",     {31'b0, bus.locked}, {31'b0, mon_e.locked});
        check_val("frame_cnt",  {16'b0, bus.frame_cnt}, {16'b0, mon_e.cnt});
      end
      vld_gap = strobe_cnt - last_vld_strobe;
      last_vld_strobe = strobe_cnt;
    end
    vld_prev = bus.data_vld;
  end

  task automatic send_bit(input logic b, input int pace);
    @(negedge clk);
    bus.en      = 1'b1;
    bus.data_in = b;
    for (int i = 1; i < pace; i++) begin
      @(negedge clk);
      bus.en      = 1'b0;
      bus.data_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int pace);
    for (int i = 7; i >= 0; i--) send_bit(v[i], pace);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic p, input int pace);
    exp_t e;
    logic err;
    send_byte(8'hA5, pace);
    for (int i = 31; i >= 0; i--) send_bit(w[i], pace);
    err = (^w) ^ p;
    if (err) begin
      m_locked = 1'b0;
    end else begin
      m_locked = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.data = w; e.perr = err; e.locked = m_locked; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    bus.en      = 1'b1;
    bus.data_in = p;
    @(posedge clk);
    #2;
    check_val("vld_latency", {31'b0, bus.data_vld}, 32'd1);
    if (pace > 1) begin
      bus.en = 1'b0;
      repeat (pace - 1) @(negedge clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_data_out"},   bus.data_out, 32'h0);
    check_val({tag, "_data_vld"},   {31'b0, bus.data_vld}, 32'd0);
    check_val({tag, "_parity_err"}, {31'b0, bus.parity_err}, 32'd0);
    check_val({tag, "_locked"},     {31'b0, bus.locked}, 32'd0);
    check_val({tag, "_frame_cnt"},  {16'b0, bus.frame_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Continuous strobes, good frame.
    send_frame(32'hDEADBEEF, 1'b0, 1);
    idle(4);
    // Same payload, wrong parity bit.
    send_frame(32'hDEADBEEF, 1'b1, 1);
    idle(4);
    // One strobe every 8 clocks with noise on the line between strobes.
    send_frame(32'h12345678, 1'b0, 8);
    idle(4);

    // Line noise first, then two back-to-back frames.
    send_byte(8'h5A, 1);
    send_byte(8'hA4, 1);
    send_frame(32'hCAFEF00D, ^32'hCAFEF00D, 1);
    send_frame(32'h0F0F0F0F, ^32'h0F0F0F0F, 1);
    check_val("b2b_gap", 32'(vld_gap), 32'd41);
    idle(4);

    // Reset in the middle of a payload.
    send_byte(8'hA5, 1);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    #1 rst = 1'b0;
    m_locked = 1'b0;
    m_cnt    = 16'h0;
    idle(2);
    send_frame(32'hA5A5_5A5A, ^32'hA5A55A5A, 1);
    idle(4);

    // Counter saturation.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check_val("cnt_forced", {16'b0, bus.frame_cnt}, 32'h0000FFFE);
    m_cnt = 16'hFFFE;
    send_frame(32'h00000000, 1'b0, 1);
    send_frame(32'hFFFFFFFF, 1'b0, 1);
    send_frame(32'h00000001, 1'b1, 1);
    idle(6);

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
